carry_resolve_adder: RTL
========================

Name: carry_resolve_adder

Overview:
- Sequential downstream stage for the n-bit half-adder array.
- Consumes the per-bit Sum and Carry vectors that the array produces (value = Sum + 2*Carry) and resolves them into a true N-bit sum plus carry-out.
- Resolution is iterative: one half-add step per clock until the carry vector is zero.
- Gives the lab datapath a complete adder built only from half-add cells, plus a start/done handshake.

Parameters:
- N, 4, operand width in bits; N >= 2.
- CW, $clog2(N+1), width of the Iterations output (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  load request; sampled on the rising edge of clk.
- Sum_in  input  N  sum vector from the half-adder array.
- Carry_in  input  N  carry vector from the half-adder array; bit i has weight 2^(i+1).
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when the result is valid.
- Result  output  N  resolved N-bit sum.
- Cout  output  1  carry-out, bit N of the sum.
- Iterations  output  CW  number of half-add steps used.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low; assertion takes effect immediately, without a clock edge.
- Reset values: state = IDLE, busy = 0, done = 0, Result = 0, Cout = 0, Iterations = 0, internal S = 0, internal C = 0.
- Internal registers: S[N-1:0], C[N-1:0], Cout, and the iteration counter.
- State machine states: IDLE, RUN, DONE.
- IDLE or DONE with start = 1:
  - Load S <= Sum_in, C <= Carry_in; clear Cout and Iterations.
  - If Carry_in == 0, next state is DONE (zero iterations). Otherwise next state is RUN.
- IDLE with start = 0: stay in IDLE.
- DONE with start = 0: go to IDLE.
- RUN, every clock, with Cs = {C[N-2:0], 1'b0}:
  - Cout <= Cout | C[N-1].
  - S <= S ^ Cs.
  - C <= S & Cs.
  - Iterations <= Iterations + 1.
  - If (S & Cs) == 0, next state is DONE; otherwise stay in RUN.
- Termination: RUN always ends within N cycles, because Cs gains a trailing zero every step. The counter never exceeds N.
- Outputs:
  - busy = (state == RUN).
  - done = (state == DONE), so it is high for exactly one cycle per operation.
  - Result = S.
  - Result, Cout and Iterations hold until the next accepted start.
- Latency: start edge -> done high after k+1 clocks, where k is the number of iterations (0..N).
- start while in RUN is ignored; no queuing, and the in-flight operation is unaffected.
- start in the DONE cycle is accepted: DONE transitions to the load, giving back-to-back operation with no dead cycle.
- Inputs are sampled only on the accepted start edge. Later changes to Sum_in or Carry_in have no effect.
- Arithmetic contract: when Sum_in & Carry_in == 0 (always true for half-adder outputs), {Cout, Result} == Sum_in + 2*Carry_in. For other inputs, Result is the value mod 2^N and Cout is the sticky OR of all carry bits shifted out.
- Reset asserted mid-RUN: immediately return to IDLE with all outputs at their reset values. No done pulse is produced, and a fresh start is required after rst_n deasserts.

Test Plan:
- A=0111, B=0001 (Sum_in=0110, Carry_in=0001), start pulse -> busy for 3 cycles; done on the 4th clock after start; Result=1000, Cout=0, Iterations=3.
- A=1111, B=0001 (Sum_in=1110, Carry_in=0001) -> 4 iterations; Result=0000, Cout=1, Iterations=4; done 5 clocks after start.
- Sum_in=1111, Carry_in=0000 -> busy never high; done on the 1st clock after start; Result=1111, Cout=0, Iterations=0.
- Sum_in=0000, Carry_in=1111 -> 1 iteration; Result=1110, Cout=1 (15+15=30).
- start re-pulsed during RUN with different inputs -> ignored; the original result is produced. Then start asserted in the DONE cycle -> new operation loads with no IDLE cycle between.
- rst_n pulled low mid-RUN, asynchronously between clock edges -> all outputs 0 immediately; no done pulse; the next start after release computes correctly.
- Exhaustive sweep N=4: all A, B pairs through half-add -> {Cout, Result} == A+B, and Iterations <= 4 for every pair.

Source files
------------

// File: rtl/carry_resolve_adder.sv
// Resolves a half-adder array's (Sum, Carry) vectors into a true N-bit sum and carry-out.
// Applies one half-add step per clock until no carries remain, with a start/done handshake.
module carry_resolve_adder #(
  parameter int unsigned N = 4,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  Sum_in,
  input  logic [N-1:0]  Carry_in,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  Result,
  output logic          Cout,
  output logic [CW-1:0] Iterations
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q;
  logic [N-1:0]  s_q;
  logic [N-1:0]  c_q;
  logic          cout_q;
  logic [CW-1:0] iter_q;
  logic [N-1:0]  cs;
  logic [N-1:0]  gen;

  // Carry bit i has weight 2^(i+1): align it with the sum bits.
  // The top carry bit drops out of cs and is folded into cout_q instead.
  assign cs  = {c_q[N-2:0], 1'b0};
  assign gen = s_q & cs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      s_q     <= '0;
      c_q     <= '0;
      cout_q  <= 1'b0;
      iter_q  <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            s_q     <= Sum_in;
            c_q     <= Carry_in;
            cout_q  <= 1'b0;
            iter_q  <= '0;
            state_q <= (Carry_in == '0) ? StDone : StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          cout_q  <= cout_q | c_q[N-1];
          s_q     <= s_q ^ cs;
          c_q     <= gen;
          iter_q  <= iter_q + CW'(1);
          state_q <= (gen == '0) ? StDone : StRun;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = (state_q == StRun);
  assign done       = (state_q == StDone);
  assign Result     = s_q;
  assign Cout       = cout_q;
  assign Iterations = iter_q;

endmodule
